// File: rtl/hams_pkg.sv
// Shared definitions for the hams merge tree: FSM encoding and key-order helpers.
package hams_pkg;

  localparam int MAX_KEY_W = 64;

  typedef logic [1:0] merge_st_e;
  localparam merge_st_e ST_MERGE   = 2'd0;
  localparam merge_st_e ST_DRAIN_A = 2'd1;
  localparam merge_st_e ST_DRAIN_B = 2'd2;

  // True when x must leave before y; equality favours x so merges stay stable.
  function automatic logic key_first(input logic ascend,
                                     input logic [MAX_KEY_W-1:0] x,
                                     input logic [MAX_KEY_W-1:0] y);
    return ascend ? (x <= y) : (x >= y);
  endfunction

  function automatic logic key_out_of_order(input logic ascend,
                                            input logic [MAX_KEY_W-1:0] key,
                                            input logic [MAX_KEY_W-1:0] prev);
    return ascend ? (key < prev) : (key > prev);
  endfunction

endpackage

// File: rtl/hams_run_order_chk.sv
// Watches the records popped from one input FIFO and flags any run that is not sorted.
module hams_run_order_chk
  import hams_pkg::*;
#(
  parameter int KEY_W  = 32,
  parameter bit ASCEND = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pop,
  input  logic [KEY_W:0]   rec,
  output logic             err
);

  logic [KEY_W-1:0] prev_key_reg;
  logic             have_prev_reg;
  logic             err_reg;
  logic             rec_last;
  logic [KEY_W-1:0] rec_key;

  assign rec_last = rec[KEY_W];
  assign rec_key  = rec[KEY_W-1:0];

  // The first record of every run has nothing to compare against.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_key_reg  <= '0;
      have_prev_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else if (pop) begin
      prev_key_reg  <= rec_key;
      have_prev_reg <= !rec_last;
      if (have_prev_reg &&
          key_out_of_order(ASCEND, MAX_KEY_W'(rec_key), MAX_KEY_W'(prev_key_reg)))
        err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

endmodule

// File: rtl/hams_merge2.sv
// Two-way sorted-run merger: pops heads of runs A and B, pushes one merged run per pair.
module hams_merge2
  import hams_pkg::*;
#(
  parameter int KEY_W  = 32,
  parameter bit ASCEND = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_empty,
  input  logic [KEY_W:0]   a_data,
  output logic             a_pop,
  input  logic             b_empty,
  input  logic [KEY_W:0]   b_data,
  output logic             b_pop,
  input  logic             o_full,
  output logic             o_push,
  output logic [KEY_W:0]   o_data,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] elem_cnt,
  output logic             order_err
);

  typedef struct packed {
    logic             last;
    logic [KEY_W-1:0] key;
  } rec_t;

  rec_t             a_rec;
  rec_t             b_rec;
  merge_st_e        state_reg;
  merge_st_e        state_next;
  logic [CNT_W-1:0] run_cnt_reg;
  logic [CNT_W-1:0] elem_cnt_reg;
  logic             run_done;
  logic             sel_a;
  logic             a_err;
  logic             b_err;

  assign a_rec = a_data;
  assign b_rec = b_data;
  assign sel_a = key_first(ASCEND, MAX_KEY_W'(a_rec.key), MAX_KEY_W'(b_rec.key));

  // While both runs are open the last flag is suppressed; the drain state forwards it.
  always_comb begin
    state_next = state_reg;
    a_pop      = 1'b0;
    b_pop      = 1'b0;
    o_push     = 1'b0;
    o_data     = '0;
    run_done   = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_MERGE: begin
          if (!a_empty && !b_empty && !o_full) begin
            o_push = 1'b1;
            if (sel_a) begin
              a_pop  = 1'b1;
              o_data = {1'b0, a_rec.key};
              if (a_rec.last)
                state_next = ST_DRAIN_B;
            end else begin
              b_pop  = 1'b1;
              o_data = {1'b0, b_rec.key};
              if (b_rec.last)
                state_next = ST_DRAIN_A;
            end
          end
        end
        ST_DRAIN_A: begin
          if (!a_empty && !o_full) begin
            a_pop  = 1'b1;
            o_push = 1'b1;
            o_data = a_data;
            if (a_rec.last) begin
              state_next = ST_MERGE;
              run_done   = 1'b1;
            end
          end
        end
        ST_DRAIN_B: begin
          if (!b_empty && !o_full) begin
            b_pop  = 1'b1;
            o_push = 1'b1;
            o_data = b_data;
            if (b_rec.last) begin
              state_next = ST_MERGE;
              run_done   = 1'b1;
            end
          end
        end
        default: state_next = ST_MERGE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_MERGE;
      run_cnt_reg  <= '0;
      elem_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (o_push)
        elem_cnt_reg <= elem_cnt_reg + CNT_W'(1);
      if (run_done)
        run_cnt_reg <= run_cnt_reg + CNT_W'(1);
    end
  end

  hams_run_order_chk #(.KEY_W(KEY_W), .ASCEND(ASCEND)) u_chk_a (
    .clk (clk),
    .rst (rst),
    .pop (a_pop),
    .rec (a_data),
    .err (a_err)
  );

  hams_run_order_chk #(.KEY_W(KEY_W), .ASCEND(ASCEND)) u_chk_b (
    .clk (clk),
    .rst (rst),
    .pop (b_pop),
    .rec (b_data),
    .err (b_err)
  );

  assign run_cnt   = run_cnt_reg;
  assign elem_cnt  = elem_cnt_reg;
  assign order_err = a_err | b_err;

endmodule

// File: tb/tb_hams_merge2.sv
// Bench for hams_merge2: an ascending and a descending instance fed from queue FIFO models.
module tb_hams_merge2;

  localparam int KW = 16;
  localparam int CW = 16;
  typedef logic [KW:0] rec_t;
  typedef int karr_t [8];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_empty [2];
  logic          b_empty [2];
  logic          o_full  [2];
  rec_t          a_data  [2];
  rec_t          b_data  [2];
  logic          a_pop   [2];
  logic          b_pop   [2];
  logic          o_push  [2];
  rec_t          o_data  [2];
  logic [CW-1:0] run_cnt [2];
  logic [CW-1:0] elem_cnt[2];
  logic          order_err[2];

  hams_merge2 #(.KEY_W(KW), .ASCEND(1'b1), .CNT_W(CW)) dut_asc (
    .clk(clk), .rst(rst),
    .a_empty(a_empty[0]), .a_data(a_data[0]), .a_pop(a_pop[0]),
    .b_empty(b_empty[0]), .b_data(b_data[0]), .b_pop(b_pop[0]),
    .o_full(o_full[0]), .o_push(o_push[0]), .o_data(o_data[0]),
    .run_cnt(run_cnt[0]), .elem_cnt(elem_cnt[0]), .order_err(order_err[0])
  );

  hams_merge2 #(.KEY_W(KW), .ASCEND(1'b0), .CNT_W(CW)) dut_desc (
    .clk(clk), .rst(rst),
    .a_empty(a_empty[1]), .a_data(a_data[1]), .a_pop(a_pop[1]),
    .b_empty(b_empty[1]), .b_data(b_data[1]), .b_pop(b_pop[1]),
    .o_full(o_full[1]), .o_push(o_push[1]), .o_data(o_data[1]),
    .run_cnt(run_cnt[1]), .elem_cnt(elem_cnt[1]), .order_err(order_err[1])
  );

  // FIFO models, expected output stream and logs of what the DUT actually did
  rec_t qa    [2][$];
  rec_t qb    [2][$];
  rec_t exp_q [2][$];
  rec_t got_q [2][$];
  int   cyc_q [2][$];
  byte  src_q [2][$];
  int   exp_runs [2];
  int   exp_elems[2];
  bit   exp_err  [2];
  int   starve_b [2];
  bit   sv_pa    [2];
  bit   sv_pb    [2];
  int   full_mode = 0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic rec_t mkrec(input bit last, input int key);
    return {last, KW'(key)};
  endfunction

  task automatic drive(input int d);
    a_empty[d] = (qa[d].size() == 0);
    a_data[d]  = (qa[d].size() != 0) ? qa[d][0] : '0;
    b_empty[d] = (qb[d].size() == 0) || (starve_b[d] > 0);
    b_data[d]  = (qb[d].size() != 0) ? qb[d][0] : '0;
    if (starve_b[d] > 0) starve_b[d]--;
    case (full_mode)
      0:       o_full[d] = 1'b0;
      1:       o_full[d] = !o_full[d];
      default: o_full[d] = ($urandom_range(0, 2) == 0);
    endcase
  endtask

  // Compare process: every cycle checks the handshake rules and each pushed record.
  initial begin : driver
    for (int d = 0; d < 2; d++) begin
      starve_b[d] = 0;
      o_full[d] = 1'b0;
      drive(d);
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        logic [5:0] viol;
        viol = {a_pop[d] && a_empty[d], b_pop[d] && b_empty[d], o_push[d] && o_full[d],
                a_pop[d] && b_pop[d], (a_pop[d] || b_pop[d]) != o_push[d],
                rst && (a_pop[d] || b_pop[d] || o_push[d])};
        check($sformatf("protocol_dut%0d", d), 64'(viol), 64'd0);
        if (o_push[d] && !o_full[d] && !rst) begin
          if (exp_q[d].size() == 0) begin
            check($sformatf("unexpected_push_dut%0d", d), 64'(o_data[d]), 64'h1_0000_0000);
          end else begin
            rec_t e;
            e = exp_q[d].pop_front();
            check($sformatf("o_data_dut%0d", d), 64'(o_data[d]), 64'(e));
          end
          got_q[d].push_back(o_data[d]);
          cyc_q[d].push_back(cyc);
          src_q[d].push_back(a_pop[d] ? "A" : "B");
        end
        sv_pa[d] = a_pop[d] && !a_empty[d] && !rst;
        sv_pb[d] = b_pop[d] && !b_empty[d] && !rst;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (sv_pa[d]) void'(qa[d].pop_front());
        if (sv_pb[d]) void'(qb[d].pop_front());
        drive(d);
      end
    end
  end

  // Reference merge: walk both runs with two cursors, the earlier key (A on ties) goes first.
  task automatic load_pair(input int d, input karr_t ka, input int na, input karr_t kb, input int nb);
    bit asc;
    int i, j, n;
    asc = (d == 0);
    for (int k = 0; k < na; k++) qa[d].push_back(mkrec(k == na - 1, ka[k]));
    for (int k = 0; k < nb; k++) qb[d].push_back(mkrec(k == nb - 1, kb[k]));
    i = 0; j = 0; n = 0;
    while (i < na || j < nb) begin
      int key;
      if (j >= nb || (i < na && (asc ? ka[i] <= kb[j] : ka[i] >= kb[j]))) begin
        key = ka[i]; i++;
      end else begin
        key = kb[j]; j++;
      end
      n++;
      exp_q[d].push_back(mkrec(n == na + nb, key));
    end
    for (int k = 1; k < na; k++)
      if (asc ? ka[k] < ka[k-1] : ka[k] > ka[k-1]) exp_err[d] = 1'b1;
    for (int k = 1; k < nb; k++)
      if (asc ? kb[k] < kb[k-1] : kb[k] > kb[k-1]) exp_err[d] = 1'b1;
    exp_runs[d]++;
    exp_elems[d] += na + nb;
  endtask

  task automatic wait_drain(input int d, input int budget);
    int n = 0;
    while ((exp_q[d].size() != 0 || qa[d].size() != 0 || qb[d].size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain_timeout_dut%0d", d), 64'(n >= budget), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic end_checks(input int d, input string tag);
    check({tag, "_run_cnt"}, 64'(run_cnt[d]), 64'(CW'(exp_runs[d])));
    check({tag, "_elem_cnt"}, 64'(elem_cnt[d]), 64'(CW'(exp_elems[d])));
    check({tag, "_order_err"}, 64'(order_err[d]), 64'(exp_err[d]));
  endtask

  task automatic clear_logs(input int d);
    got_q[d].delete();
    cyc_q[d].delete();
    src_q[d].delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_runs[d] = 0;
      exp_elems[d] = 0;
      exp_err[d] = 1'b0;
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    karr_t ka, kb;
    int exp_keys[6];
    int load_cyc;
    for (int d = 0; d < 2; d++) begin
      exp_runs[d] = 0; exp_elems[d] = 0; exp_err[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_run_cnt", 64'(run_cnt[d]), 64'd0);
      check("reset_elem_cnt", 64'(elem_cnt[d]), 64'd0);
      check("reset_order_err", 64'(order_err[d]), 64'd0);
    end

    // Basic ascending merge, no stalls
    exp_keys = '{1, 2, 3, 4, 7, 9};
    clear_logs(0);
    ka = '{1, 4, 7, 0, 0, 0, 0, 0};
    kb = '{2, 3, 9, 0, 0, 0, 0, 0};
    load_pair(0, ka, 3, kb, 3);
    wait_drain(0, 100);
    for (int i = 0; i < 6; i++)
      check($sformatf("t1_rec%0d", i), 64'(got_q[0][i]), 64'(mkrec(i == 5, exp_keys[i])));
    check("t1_consecutive", 64'(cyc_q[0][5] - cyc_q[0][0]), 64'd5);
    check("t1_run_cnt", 64'(run_cnt[0]), 64'd1);
    check("t1_elem_cnt", 64'(elem_cnt[0]), 64'd6);
    end_checks(0, "t1");

    // Ties resolve to A
    clear_logs(0);
    ka = '{5, 5, 0, 0, 0, 0, 0, 0};
    kb = '{5, 0, 0, 0, 0, 0, 0, 0};
    load_pair(0, ka, 2, kb, 1);
    wait_drain(0, 100);
    check("t2_src0", 64'(src_q[0][0]), 64'("A"));
    check("t2_src1", 64'(src_q[0][1]), 64'("A"));
    check("t2_src2", 64'(src_q[0][2]), 64'("B"));
    check("t2_last", 64'(got_q[0][2]), 64'(mkrec(1'b1, 5)));
    end_checks(0, "t2");

    // Backpressure toggling every cycle
    full_mode = 1;
    clear_logs(0);
    ka = '{1, 4, 7, 0, 0, 0, 0, 0};
    kb = '{2, 3, 9, 0, 0, 0, 0, 0};
    load_pair(0, ka, 3, kb, 3);
    wait_drain(0, 100);
    full_mode = 0;
    check("t3_count", 64'(got_q[0].size()), 64'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_rec%0d", i), 64'(got_q[0][i]), 64'(mkrec(i == 5, exp_keys[i])));
    end_checks(0, "t3");

    // B starved for ten cycles while in merge
    clear_logs(0);
    starve_b[0] = 10;
    load_cyc = cyc;
    load_pair(0, ka, 3, kb, 3);
    repeat (10) @(negedge clk);
    check("t4_no_push_starved", 64'(got_q[0].size()), 64'd0);
    wait_drain(0, 100);
    for (int i = 0; i < 6; i++)
      check($sformatf("t4_rec%0d", i), 64'(got_q[0][i]), 64'(mkrec(i == 5, exp_keys[i])));
    check("t4_waited", 64'(cyc_q[0][0] - load_cyc >= 10), 64'd1);
    end_checks(0, "t4");

    // Unsorted run A, then reset clears the flag and counters
    clear_logs(0);
    ka = '{8, 3, 0, 0, 0, 0, 0, 0};
    kb = '{9, 0, 0, 0, 0, 0, 0, 0};
    load_pair(0, ka, 2, kb, 1);
    wait_drain(0, 100);
    check("t5_rec0", 64'(got_q[0][0]), 64'(mkrec(1'b0, 8)));
    check("t5_rec1", 64'(got_q[0][1]), 64'(mkrec(1'b0, 3)));
    check("t5_rec2", 64'(got_q[0][2]), 64'(mkrec(1'b1, 9)));
    check("t5_order_err", 64'(order_err[0]), 64'd1);
    end_checks(0, "t5");
    repeat (5) @(negedge clk);
    check("t5_order_err_sticky", 64'(order_err[0]), 64'd1);
    pulse_reset();
    check("t5_rst_order_err", 64'(order_err[0]), 64'd0);
    check("t5_rst_run_cnt", 64'(run_cnt[0]), 64'd0);
    check("t5_rst_elem_cnt", 64'(elem_cnt[0]), 64'd0);
    clear_logs(0);
    ka = '{1, 3, 0, 0, 0, 0, 0, 0};
    kb = '{2, 0, 0, 0, 0, 0, 0, 0};
    load_pair(0, ka, 2, kb, 1);
    wait_drain(0, 100);
    check("t5_merge_after_rst", 64'(got_q[0][1]), 64'(mkrec(1'b0, 2)));
    end_checks(0, "t5r");

    // Descending instance, two pairs back to back
    clear_logs(1);
    ka = '{9, 2, 0, 0, 0, 0, 0, 0};
    kb = '{5, 1, 0, 0, 0, 0, 0, 0};
    load_pair(1, ka, 2, kb, 2);
    ka = '{8, 6, 4, 0, 0, 0, 0, 0};
    kb = '{7, 0, 0, 0, 0, 0, 0, 0};
    load_pair(1, ka, 3, kb, 1);
    wait_drain(1, 100);
    check("t6_rec0", 64'(got_q[1][0]), 64'(mkrec(1'b0, 9)));
    check("t6_rec1", 64'(got_q[1][1]), 64'(mkrec(1'b0, 5)));
    check("t6_rec2", 64'(got_q[1][2]), 64'(mkrec(1'b0, 2)));
    check("t6_rec3", 64'(got_q[1][3]), 64'(mkrec(1'b1, 1)));
    check("t6_no_idle", 64'(cyc_q[1][7] - cyc_q[1][0]), 64'd7);
    end_checks(1, "t6");

    // Randomized sorted runs with random backpressure and starvation
    full_mode = 2;
    for (int batch = 0; batch < 6; batch++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 4; p++) begin
          int na, nb, va, vb;
          na = $urandom_range(1, 5);
          nb = $urandom_range(1, 5);
          va = (d == 0) ? $urandom_range(0, 5) : 60 - $urandom_range(0, 5);
          vb = (d == 0) ? $urandom_range(0, 5) : 60 - $urandom_range(0, 5);
          for (int k = 0; k < 8; k++) begin
            ka[k] = va;
            kb[k] = vb;
            va = (d == 0) ? va + $urandom_range(0, 3) : va - $urandom_range(0, 3);
            vb = (d == 0) ? vb + $urandom_range(0, 3) : vb - $urandom_range(0, 3);
          end
          load_pair(d, ka, na, kb, nb);
        end
        if ($urandom_range(0, 1) == 1) starve_b[d] = $urandom_range(1, 6);
      end
      wait_drain(0, 2000);
      wait_drain(1, 2000);
      end_checks(0, $sformatf("rand%0d_dut0", batch));
      end_checks(1, $sformatf("rand%0d_dut1", batch));
    end
    full_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
